// File: rtl/call_request_panel_if.sv
// Signal bundle between the push-button panel and the elevator controller side.
// The master drives raw buttons and controller status; the slave returns the latched requests.
interface call_request_panel_if;
    logic [2:0] raw_up;
    logic [2:0] raw_down;
    logic [3:0] raw_in;
    logic [2:0] position;
    logic       open;
    logic [1:0] direction;
    logic [2:0] button_up;
    logic [2:0] button_down;
    logic [3:0] button_in;
    logic [7:0] serviced_cnt;

    modport master (
        output raw_up, raw_down, raw_in, position, open, direction,
        input  button_up, button_down, button_in, serviced_cnt
    );

    modport slave (
        input  raw_up, raw_down, raw_in, position, open, direction,
        output button_up, button_down, button_in, serviced_cnt
    );
endinterface

// File: rtl/call_request_panel.sv
// Latches hall and cab button presses as call requests and clears each one when the
// car stands at its floor with the door open and a compatible direction.
module call_request_panel (
    input  logic                 clk,
    input  logic                 reset,
    call_request_panel_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} req_state_t;

    localparam int NREQ = 10;

    // Request vector layout: [2:0] hall up, [5:3] hall down, [9:6] cab.
    logic [NREQ-1:0] raw_all;
    logic [NREQ-1:0] raw_p1;
    logic [NREQ-1:0] press;
    logic [NREQ-1:0] clr;
    logic [NREQ-1:0] pending;
    logic [3:0]      svc;
    logic            dir_up_ok;
    logic            dir_dn_ok;
    logic            serviced;
    logic [7:0]      cnt_q;
    logic [7:0]      cnt_d;
    req_state_t      state_q [NREQ];
    req_state_t      state_d [NREQ];

    assign raw_all = {bus.raw_in, bus.raw_down, bus.raw_up};
    assign press   = raw_all & ~raw_p1;

    always_comb begin
        svc = '0;
        for (int f = 0; f < 4; f++) begin
            svc[f] = !bus.position[0] && (bus.position[2:1] == 2'(f)) && bus.open;
        end
    end

    // Direction 11 is treated as unknown: only cab calls may be answered.
    assign dir_up_ok = (bus.direction == 2'b00) || (bus.direction == 2'b01);
    assign dir_dn_ok = (bus.direction == 2'b00) || (bus.direction == 2'b10);

    assign clr = {svc, svc[3:1] & {3{dir_dn_ok}}, svc[2:0] & {3{dir_up_ok}}};

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            state_d[i] = state_q[i];
            pending[i] = (state_q[i] == PENDING);
            case (state_q[i])
                IDLE:    if (press[i] && !clr[i]) state_d[i] = PENDING;
                PENDING: if (clr[i])              state_d[i] = IDLE;
                default:                          state_d[i] = IDLE;
            endcase
        end
    end

    // One increment per edge however many requests are answered together.
    assign serviced = |(pending & clr);
    assign cnt_d    = (serviced && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_p1 <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < NREQ; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            raw_p1 <= raw_all;
            cnt_q  <= cnt_d;
            for (int i = 0; i < NREQ; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    assign bus.button_up    = pending[2:0];
    assign bus.button_down  = pending[5:3];
    assign bus.button_in    = pending[9:6];
    assign bus.serviced_cnt = cnt_q;
endmodule
